// File: rtl/vid_box_overlay_out.sv
// VGA output stage: bounding-box overlay, 2-clk re-timing of video/syncs, frame geometry measurement.
// Optional underflow counter enabled by defining VID_UNDERFLOW_CNT_EN.
module vid_box_overlay_out #(
    parameter int          BORDER_W = 2,
    parameter logic [23:0] BOX_RGB  = 24'hFF0000,
    parameter int          CNT_W    = 12
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [23:0]      vid_data,
    input  logic             vid_datavalid,
    input  logic             vid_h_sync,
    input  logic             vid_v_sync,
    input  logic             vid_v,
    input  logic             vid_underflow,
    input  logic             box_en,
    input  logic [CNT_W-1:0] box_x0,
    input  logic [CNT_W-1:0] box_x1,
    input  logic [CNT_W-1:0] box_y0,
    input  logic [CNT_W-1:0] box_y1,
    output logic [7:0]       vga_r,
    output logic [7:0]       vga_g,
    output logic [7:0]       vga_b,
    output logic             vga_hs,
    output logic             vga_vs,
    output logic             vga_blank_n,
    output logic [CNT_W-1:0] frame_width,
    output logic [CNT_W-1:0] frame_height,
    output logic [15:0]      frame_cnt,
    output logic             locked,
    output logic [15:0]      uf_count,
    output logic             uf_sticky
);

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
    localparam logic [CNT_W:0]   BW      = (CNT_W+1)'(BORDER_W);

    logic             dv_d, v_d;
    logic [CNT_W-1:0] x, y, line_w;
    logic [CNT_W-1:0] x_inc, px, y_nxt, line_w_nxt;
    logic             line_end, vb_entry;

    logic             sh_en;
    logic [CNT_W-1:0] sh_x0, sh_x1, sh_y0, sh_y1;
    logic [CNT_W:0]   ex, ey, ex0, ex1, ey0, ey1;
    logic             box_ok, in_rect, in_band, hit;

    logic [23:0]      data_s1;
    logic             dv_s1, hs_s1, vs_s1, hit_s1;

    // x holds the coordinate of the last active pixel; px is the coordinate of the pixel now at the input
    always_comb begin
        x_inc      = (x == CNT_MAX) ? x : x + 1'b1;
        px         = dv_d ? x_inc : '0;
        line_end   = dv_d & ~vid_datavalid;
        vb_entry   = vid_v & ~v_d;
        y_nxt      = y;
        line_w_nxt = line_w;
        if (line_end) begin
            y_nxt      = (y == CNT_MAX) ? y : y + 1'b1;
            line_w_nxt = x_inc;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            dv_d   <= 1'b0;
            v_d    <= 1'b0;
            x      <= '0;
            y      <= '0;
            line_w <= '0;
        end else begin
            dv_d   <= vid_datavalid;
            v_d    <= vid_v;
            line_w <= line_w_nxt;
            y      <= vb_entry ? '0 : y_nxt;
            if (line_end)
                x <= '0;
            else if (vid_datavalid)
                x <= px;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            frame_width  <= '0;
            frame_height <= '0;
            frame_cnt    <= '0;
            locked       <= 1'b0;
            sh_en        <= 1'b0;
            sh_x0        <= '0;
            sh_x1        <= '0;
            sh_y0        <= '0;
            sh_y1        <= '0;
        end else if (vb_entry) begin
            frame_width  <= line_w_nxt;
            frame_height <= y_nxt;
            frame_cnt    <= frame_cnt + 1'b1;
            locked       <= 1'b1;
            sh_en        <= box_en;
            sh_x0        <= box_x0;
            sh_x1        <= box_x1;
            sh_y0        <= box_y0;
            sh_y1        <= box_y1;
        end
    end

    // One extra bit keeps x0+BW from wrapping; x1-BW is evaluated as x+BW > x1 so it never underflows
    always_comb begin
        ex      = {1'b0, px};
        ey      = {1'b0, y};
        ex0     = {1'b0, sh_x0};
        ex1     = {1'b0, sh_x1};
        ey0     = {1'b0, sh_y0};
        ey1     = {1'b0, sh_y1};
        box_ok  = locked && sh_en && (ex0 <= ex1) && (ey0 <= ey1);
        in_rect = (ex >= ex0) && (ex <= ex1) && (ey >= ey0) && (ey <= ey1);
        in_band = (ex < ex0 + BW) || (ex + BW > ex1) || (ey < ey0 + BW) || (ey + BW > ey1);
        hit     = box_ok && in_rect && in_band;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            data_s1     <= '0;
            dv_s1       <= 1'b0;
            hs_s1       <= 1'b0;
            vs_s1       <= 1'b0;
            hit_s1      <= 1'b0;
            vga_r       <= '0;
            vga_g       <= '0;
            vga_b       <= '0;
            vga_hs      <= 1'b0;
            vga_vs      <= 1'b0;
            vga_blank_n <= 1'b0;
        end else begin
            data_s1     <= vid_data;
            dv_s1       <= vid_datavalid;
            hs_s1       <= vid_h_sync;
            vs_s1       <= vid_v_sync;
            hit_s1      <= hit & vid_datavalid;
            vga_hs      <= hs_s1;
            vga_vs      <= vs_s1;
            vga_blank_n <= dv_s1;
            if (!dv_s1)
                {vga_r, vga_g, vga_b} <= '0;
            else if (hit_s1)
                {vga_r, vga_g, vga_b} <= BOX_RGB;
            else
                {vga_r, vga_g, vga_b} <= data_s1;
        end
    end

`ifdef VID_UNDERFLOW_CNT_EN
    logic uf_d;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            uf_d      <= 1'b0;
            uf_count  <= '0;
            uf_sticky <= 1'b0;
        end else begin
            uf_d <= vid_underflow;
            if (vid_underflow && !uf_d) begin
                uf_sticky <= 1'b1;
                if (uf_count != 16'hFFFF)
                    uf_count <= uf_count + 1'b1;
            end
        end
    end
`else
    logic unused_underflow;
    assign unused_underflow = vid_underflow;
    assign uf_count         = '0;
    assign uf_sticky        = 1'b0;
`endif

endmodule
